// File: rtl/wlo_host_link.sv
// wlo_host_link
// Host-side sequencer for the word-length-optimisation control link.
// Each run sends one command frame and then collects one MSE response frame.
//
// Command frame: A5, NUM_CHAN, frac[0]..frac[NUM_CHAN-1], CHK.
//   CHK is the XOR of every byte before it in the frame.
// Response frame: sync byte 5A, then 8 MSE bytes, MSB first.
//
// Ports
//   clk, rst             clock and synchronous active-high reset
//   cfg_frac, cfg_valid  fractional-width configuration offer
//   cfg_ready            high in IDLE; cfg_valid & cfg_ready starts a run
//   tx_data, tx_valid    command byte stream; a byte moves on tx_valid & tx_ready
//   tx_ready             command byte sink can accept
//   rx_data, rx_valid    response byte stream (single-cycle strobes)
//   res_mse, res_valid   last completed MSE and its one-cycle update pulse
//   res_err              one-cycle pulse when a response times out
//   busy                 high in every state except IDLE
module wlo_host_link #(
    parameter int NUM_CHAN    = 3,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*NUM_CHAN-1:0] cfg_frac,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [63:0]           res_mse,
    output logic                  res_valid,
    output logic                  res_err,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND      = 2'd1;
    localparam logic [1:0] ST_WAIT_SYNC = 2'd2;
    localparam logic [1:0] ST_RECV      = 2'd3;

    localparam int             IW       = 5;
    localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_CHAN + 2);
    localparam int             TW       = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [1:0]            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [7:0]            chk_q, chk_d;
    logic [8*NUM_CHAN-1:0] frac_q, frac_d;
    logic [55:0]           shift_q, shift_d;   // first 7 payload bytes; the 8th joins on completion
    logic [2:0]            cnt_q, cnt_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [63:0]           res_mse_q, res_mse_d;
    logic                  res_valid_q, res_valid_d;
    logic                  res_err_q, res_err_d;

    // Captured configuration split into per-channel bytes.
    logic [7:0] frac_byte [NUM_CHAN];
    generate
        for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_frac
            assign frac_byte[gi] = frac_q[8*gi +: 8];
        end
    endgenerate

    // Byte of the command frame selected by the current index.
    logic [7:0] frame_byte;
    always_comb begin
        frame_byte = 8'h00;
        if (idx_q == '0) begin
            frame_byte = 8'hA5;
        end else if (idx_q == IW'(1)) begin
            frame_byte = 8'(NUM_CHAN);
        end else if (idx_q == LAST_IDX) begin
            frame_byte = chk_q;
        end else begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                if (idx_q == IW'(i + 2)) begin
                    frame_byte = frac_byte[i];
                end
            end
        end
    end

    assign tx_valid  = (state_q == ST_SEND);
    assign tx_data   = tx_valid ? frame_byte : 8'h00;
    assign cfg_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign res_mse   = res_mse_q;
    assign res_valid = res_valid_q;
    assign res_err   = res_err_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        chk_d       = chk_q;
        frac_d      = frac_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        res_mse_d   = res_mse_q;
        res_valid_d = 1'b0;
        res_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    frac_d  = cfg_frac;
                    chk_d   = 8'h00;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    chk_d = chk_q ^ frame_byte;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        timer_d = '0;
                        state_d = ST_WAIT_SYNC;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_WAIT_SYNC: begin
                // Non-sync bytes are dropped and do not restart the timer.
                if (rx_valid && rx_data == 8'h5A) begin
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = ST_RECV;
                end else if (timer_q == TMO_LAST) begin
                    res_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RECV: begin
                // Every byte here is payload, including any 0x5A.
                if (rx_valid) begin
                    timer_d = '0;
                    if (cnt_q == 3'd7) begin
                        res_mse_d   = {shift_q, rx_data};
                        res_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        shift_d = {shift_q[47:0], rx_data};
                        cnt_d   = cnt_q + 1'b1;
                    end
                end else if (timer_q == TMO_LAST) begin
                    res_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            chk_q       <= '0;
            frac_q      <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            res_mse_q   <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            chk_q       <= chk_d;
            frac_q      <= frac_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            res_mse_q   <= res_mse_d;
            res_valid_q <= res_valid_d;
            res_err_q   <= res_err_d;
        end
    end

endmodule

// File: tb/tb_wlo_host_link.sv
// Testbench for wlo_host_link: stimulus pushes expected command bytes and
// expected results into queues; a monitor on the falling edge pops and
// compares whenever the DUT transfers a byte or pulses a result.
module tb_wlo_host_link;

    localparam int NC = 3;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic [8*NC-1:0] cfg_frac;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [63:0]   res_mse;
    logic          res_valid;
    logic          res_err;
    logic          busy;

    wlo_host_link #(.NUM_CHAN(NC), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .cfg_frac(cfg_frac), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .res_mse(res_mse), .res_valid(res_valid), .res_err(res_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [63:0] mse;
        int          at_cyc;
    } res_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          bp_mode = 0;
    int          bp_cnt = 0;
    int          hs_cyc = 0;
    int          last_xfer_cyc = 0;
    int          last_rx_edge = 0;
    logic [63:0] model_mse = 64'd0;
    logic [7:0]  exp_tx[$];
    res_t        exp_res[$];
    logic [7:0]  rx_bytes[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference frame: header, channel count, widths, then XOR of all of them.
    function automatic void push_frame(input logic [8*NC-1:0] f);
        logic [7:0] fr[$];
        logic [7:0] x;
        fr.push_back(8'hA5);
        fr.push_back(8'(NC));
        for (int i = 0; i < NC; i++) fr.push_back(f[8*i +: 8]);
        x = 8'h00;
        foreach (fr[i]) x = x ^ fr[i];
        fr.push_back(x);
        foreach (fr[i]) exp_tx.push_back(fr[i]);
    endfunction

    // Byte sink back-pressure pattern.
    initial begin
        forever begin
            @(posedge clk); #1;
            bp_cnt++;
            case (bp_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ((bp_cnt % 3) == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard.
    logic       stall_pend = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic [7:0] exp_b;
    res_t       exp_r;
    always @(negedge clk) begin
        if (rst) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("tx_hold_valid", 64'(tx_valid), 64'd1);
                check("tx_hold_data", 64'(tx_data), 64'(stall_data));
            end
            if (tx_valid) begin
                check("busy_in_send", 64'({busy, cfg_ready}), 64'b10);
                if (tx_ready) begin
                    if (exp_tx.size() == 0) begin
                        check("tx_unexpected_byte", 64'(tx_data), 64'h100);
                    end else begin
                        exp_b = exp_tx.pop_front();
                        check("tx_byte", 64'(tx_data), 64'(exp_b));
                        last_xfer_cyc = cyc;
                    end
                end
            end
            stall_pend = tx_valid && !tx_ready;
            stall_data = tx_data;

            if (res_valid || res_err) begin
                if (exp_res.size() == 0) begin
                    check("res_unexpected", 64'({res_valid, res_err}), 64'd0);
                end else begin
                    exp_r = exp_res.pop_front();
                    check("res_kind", 64'({res_valid, res_err}), exp_r.err ? 64'b01 : 64'b10);
                    check("res_idle", 64'({cfg_ready, busy}), 64'b10);
                    if (exp_r.err) begin
                        check("timeout_cycle", 64'(cyc), 64'(exp_r.at_cyc));
                        check("mse_held_on_err", res_mse, model_mse);
                    end else begin
                        check("res_mse", res_mse, exp_r.mse);
                        model_mse = exp_r.mse;
                    end
                end
            end
            if (!res_valid) check("res_mse_hold", res_mse, model_mse);
        end
    end

    task automatic check_reset_vals();
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_res_mse", res_mse, 64'd0);
        check("rst_res_pulses", 64'({res_valid, res_err}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    endtask

    task automatic start_cfg(input logic [8*NC-1:0] f);
        int n = 0;
        while (!cfg_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("cfg_ready_wait", 64'(cfg_ready), 64'd1);
        cfg_frac  = f;
        cfg_valid = 1'b1;
        hs_cyc    = cyc + 1;
        push_frame(f);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    // Wait for the frame to drain; optionally inject ignored rx/cfg traffic.
    task automatic wait_frame(input bit noise);
        int n = 0;
        while (exp_tx.size() != 0 && n < 500) begin
            if (noise) begin
                rx_valid  = 1'($urandom_range(0, 1));
                rx_data   = $urandom_range(0, 1) ? 8'h5A : 8'($urandom);
                cfg_valid = 1'($urandom_range(0, 1));
                cfg_frac  = (8*NC)'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        rx_valid  = 1'b0;
        cfg_valid = 1'b0;
        check("frame_drained", 64'(exp_tx.size()), 64'd0);
        check("busy_after_frame", 64'({busy, tx_valid}), 64'b10);
    endtask

    task automatic drive_rx(input int max_gap);
        foreach (rx_bytes[i]) begin
            rx_valid     = 1'b1;
            rx_data      = rx_bytes[i];
            last_rx_edge = cyc + 1;
            @(posedge clk); #1;
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_res();
        int n = 0;
        while (exp_res.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("res_arrived", 64'(exp_res.size()), 64'd0);
        check("idle_after_run", 64'(cfg_ready), 64'd1);
    endtask

    function automatic logic [63:0] bytes_to_mse(input int first);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < 8; i++) v = (v << 8) | 64'(rx_bytes[first + i]);
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        logic [8*NC-1:0] f;
        int nj;
        int np;

        rst = 1'b1; cfg_valid = 1'b0; cfg_frac = '0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals();

        // Directed frame with tx_ready tied high, response with leading junk.
        bp_mode = 0;
        start_cfg({8'd8, 8'd10, 8'd12});
        wait_frame(1'b0);
        check("frame_consecutive", 64'(last_xfer_cyc - hs_cyc), 64'(NC + 2));
        rx_bytes = '{8'h11, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h2C, 8'h5A};
        r.err = 1'b0; r.mse = bytes_to_mse(2); r.at_cyc = 0;
        exp_res.push_back(r);
        drive_rx(0);
        wait_res();

        // Back-pressure 1-of-3, payload starting with the sync value.
        bp_mode = 1;
        start_cfg({8'd8, 8'd10, 8'd12});
        wait_frame(1'b0);
        rx_bytes = '{8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        r.err = 1'b0; r.mse = bytes_to_mse(1);
        exp_res.push_back(r);
        drive_rx(0);
        wait_res();

        // Timeout after sync plus 3 payload bytes.
        bp_mode = 0;
        start_cfg((8*NC)'($urandom));
        wait_frame(1'b0);
        rx_bytes = '{8'h5A, 8'h12, 8'h34, 8'h56};
        drive_rx(2);
        r.err = 1'b1; r.mse = 64'd0; r.at_cyc = last_rx_edge + TO;
        exp_res.push_back(r);
        wait_res();

        // Reset in the middle of a frame, then a clean run.
        start_cfg({8'd3, 8'd2, 8'd1});
        begin
            int n = 0;
            while (exp_tx.size() > NC && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
        end
        rst = 1'b1;
        exp_tx.delete();
        model_mse = 64'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_vals();
        start_cfg({8'd3, 8'd2, 8'd1});
        wait_frame(1'b0);
        rx_bytes = '{8'h5A, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        r.err = 1'b0; r.mse = bytes_to_mse(1);
        exp_res.push_back(r);
        drive_rx(1);
        wait_res();

        // Randomised runs.
        for (int run = 0; run < 20; run++) begin
            bp_mode = $urandom_range(0, 2);
            f = (8*NC)'({$urandom, $urandom});
            start_cfg(f);
            wait_frame(1'b1);
            rx_bytes.delete();
            if ($urandom_range(0, 5) == 0) begin
                np = $urandom_range(0, 7);
                rx_bytes.push_back(8'h5A);
                for (int i = 0; i < np; i++) rx_bytes.push_back(8'($urandom));
                drive_rx(3);
                r.err = 1'b1; r.mse = 64'd0; r.at_cyc = last_rx_edge + TO;
                exp_res.push_back(r);
            end else begin
                nj = $urandom_range(0, 2);
                for (int i = 0; i < nj; i++) begin
                    logic [7:0] j = 8'($urandom);
                    rx_bytes.push_back((j == 8'h5A) ? 8'h11 : j);
                end
                rx_bytes.push_back(8'h5A);
                for (int i = 0; i < 8; i++)
                    rx_bytes.push_back(($urandom_range(0, 3) == 0) ? 8'h5A : 8'($urandom));
                r.err = 1'b0; r.mse = bytes_to_mse(nj + 1); r.at_cyc = 0;
                exp_res.push_back(r);
                drive_rx(3);
            end
            wait_res();
        end

        repeat (3) @(posedge clk);
        #1;
        check("tx_queue_empty", 64'(exp_tx.size()), 64'd0);
        check("res_queue_empty", 64'(exp_res.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
